rf_wb_arb: RTL and testbench

- Write-back arbiter directly upstream of the CPU register file unit. It owns the single RF write port (wen/rd_addr/rd_data).
- Merges the in-order pipeline write-back with out-of-order long-latency results (divider, load miss), buffering the latter in a small FIFO.
- Keeps a per-GPR busy scoreboard so decode can stall on pending long-latency destinations.

---
 rtl/rf_wb_arb.sv | 135 +++++++++++++
 tb/tb_rf_wb_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arb.sv
// Write-back arbiter owning the single RF write port: pipeline write-back wins,
// long-latency results queue in a small FIFO, and a per-GPR busy scoreboard
// tracks pending destinations. Define RF_WB_FWD_EN to add write-port forwarding outputs.
module rf_wb_arb #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_wen,
  input  logic [4:0]      pipe_rd_addr,
  input  logic [XLEN-1:0] pipe_rd_data,
  input  logic            lat_valid,
  output logic            lat_ready,
  input  logic [4:0]      lat_rd_addr,
  input  logic [XLEN-1:0] lat_rd_data,
  input  logic            sb_set,
  input  logic [4:0]      sb_set_addr,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_wen,
  output logic [4:0]      rf_rd_addr,
  output logic [XLEN-1:0] rf_rd_data,
`ifdef RF_WB_FWD_EN
  output logic            rs1_fwd_valid,
  output logic            rs2_fwd_valid,
  output logic [XLEN-1:0] rs1_fwd_data,
  output logic [XLEN-1:0] rs2_fwd_data,
`endif
  output logic            err_waw
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      q_addr [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     busy;
  logic [31:0]     busy_next;

  logic full;
  logic empty;
  logic xfer;
  logic pop;
  logic bypass;
  logic push;
  logic clr_en;
  logic [4:0] clr_addr;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign lat_ready = !full;
  assign xfer      = lat_valid && lat_ready;
  assign pop       = !pipe_wen && !empty;
  assign bypass    = !pipe_wen && empty && xfer;
  assign push      = xfer && !bypass;
  assign clr_en    = pop || bypass;
  assign clr_addr  = pop ? q_addr[rd_ptr] : lat_rd_addr;

  // Clear first so a same-cycle set of the same register wins; x0 never goes busy.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_addr] = 1'b0;
    if (sb_set && sb_set_addr != 5'd0) busy_next[sb_set_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= lat_rd_addr;
      q_data[wr_ptr] <= lat_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen     <= 1'b0;
      rf_rd_addr <= '0;
      rf_rd_data <= '0;
      busy       <= '0;
      err_waw    <= 1'b0;
    end else begin
      busy <= busy_next;
      if (pipe_wen && pipe_rd_addr != 5'd0 && busy[pipe_rd_addr]) err_waw <= 1'b1;
      if (pipe_wen) begin
        rf_wen     <= 1'b1;
        rf_rd_addr <= pipe_rd_addr;
        rf_rd_data <= pipe_rd_data;
      end else if (pop) begin
        rf_wen     <= 1'b1;
        rf_rd_addr <= q_addr[rd_ptr];
        rf_rd_data <= q_data[rd_ptr];
      end else if (bypass) begin
        rf_wen     <= 1'b1;
        rf_rd_addr <= lat_rd_addr;
        rf_rd_data <= lat_rd_data;
      end else begin
        rf_wen <= 1'b0;
      end
    end
  end

`ifdef RF_WB_FWD_EN
  // Bridges the cycle between busy dropping and the RF array holding the value.
  assign rs1_fwd_valid = rf_wen && (rf_rd_addr == rs1_addr) && (rs1_addr != 5'd0);
  assign rs2_fwd_valid = rf_wen && (rf_rd_addr == rs2_addr) && (rs2_addr != 5'd0);
  assign rs1_fwd_data  = rf_rd_data;
  assign rs2_fwd_data  = rf_rd_data;
`endif

endmodule

// File: tb/tb_rf_wb_arb.sv
// Randomized self-checking bench for rf_wb_arb against a queue-based
// reference model, plus directed scenarios for the main corner cases.
module tb_rf_wb_arb;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst;
  logic            pipe_wen;
  logic [4:0]      pipe_rd_addr;
  logic [XLEN-1:0] pipe_rd_data;
  logic            lat_valid;
  logic            lat_ready;
  logic [4:0]      lat_rd_addr;
  logic [XLEN-1:0] lat_rd_data;
  logic            sb_set;
  logic [4:0]      sb_set_addr;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rf_wen;
  logic [4:0]      rf_rd_addr;
  logic [XLEN-1:0] rf_rd_data;
  logic            err_waw;
`ifdef RF_WB_FWD_EN
  logic            rs1_fwd_valid;
  logic            rs2_fwd_valid;
  logic [XLEN-1:0] rs1_fwd_data;
  logic [XLEN-1:0] rs2_fwd_data;
`endif

  rf_wb_arb #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_rd_addr(pipe_rd_addr), .pipe_rd_data(pipe_rd_data),
    .lat_valid(lat_valid), .lat_ready(lat_ready),
    .lat_rd_addr(lat_rd_addr), .lat_rd_data(lat_rd_data),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_wen(rf_wen), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
`ifdef RF_WB_FWD_EN
    .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
`endif
    .err_waw(err_waw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      a;
    logic [XLEN-1:0] d;
  } ent_t;

  ent_t            m_q[$];
  logic [31:0]     m_busy;
  logic            m_wen;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  logic            m_err;
  bit              model_ok = 0;

  int tests  = 0;
  int failed = 0;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock of stimulus: check combinational outputs, advance the model, check registers.
  task automatic applyStimulus(input bit r, input bit pw, input logic [4:0] pa, input logic [XLEN-1:0] pd,
                               input bit lv, input logic [4:0] la, input logic [XLEN-1:0] ld,
                               input bit ss, input logic [4:0] sa,
                               input logic [4:0] r1, input logic [4:0] r2);
    bit xfer;
    bit clr;
    logic [4:0] ca;
    ent_t e;
    rst = r; pipe_wen = pw; pipe_rd_addr = pa; pipe_rd_data = pd;
    lat_valid = lv; lat_rd_addr = la; lat_rd_data = ld;
    sb_set = ss; sb_set_addr = sa; rs1_addr = r1; rs2_addr = r2;
    #1;
    if (model_ok) begin
      checkOutput("lat_ready", lat_ready, m_q.size() < DEPTH);
      checkOutput("rs1_busy", rs1_busy, m_busy[r1]);
      checkOutput("rs2_busy", rs2_busy, m_busy[r2]);
`ifdef RF_WB_FWD_EN
      checkOutput("rs1_fwd_valid", rs1_fwd_valid, m_wen && m_addr == r1 && r1 != 0);
      checkOutput("rs2_fwd_valid", rs2_fwd_valid, m_wen && m_addr == r2 && r2 != 0);
      checkOutput("rs1_fwd_data", rs1_fwd_data, m_data);
      checkOutput("rs2_fwd_data", rs2_fwd_data, m_data);
`endif
    end
    xfer = lv && (m_q.size() < DEPTH);
    clr = 0;
    ca = '0;
    if (r) begin
      m_q.delete();
      m_busy = '0; m_wen = 0; m_addr = '0; m_data = '0; m_err = 0;
      model_ok = 1;
    end else begin
      if (pw) begin
        if (pa != 0 && m_busy[pa]) m_err = 1;
        m_wen = 1; m_addr = pa; m_data = pd;
        if (xfer) m_q.push_back('{a: la, d: ld});
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_wen = 1; m_addr = e.a; m_data = e.d;
        clr = 1; ca = e.a;
        if (xfer) m_q.push_back('{a: la, d: ld});
      end else if (xfer) begin
        m_wen = 1; m_addr = la; m_data = ld;
        clr = 1; ca = la;
      end else begin
        m_wen = 0;
      end
      if (clr && ca != 0) m_busy[ca] = 0;
      if (ss && sa != 0) m_busy[sa] = 1;
    end
    @(posedge clk);
    #1;
    checkOutput("rf_wen", rf_wen, m_wen);
    checkOutput("rf_rd_addr", rf_rd_addr, m_addr);
    checkOutput("rf_rd_data", rf_rd_data, m_data);
    checkOutput("err_waw", err_waw, m_err);
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int idx;
    logic [4:0] got[$];
    bit acc;

    doReset();
    doReset();
    checkOutput("rst_rf_wen", rf_wen, 0);
    checkOutput("rst_lat_ready", lat_ready, 1);
    checkOutput("rst_err", err_waw, 0);

    // Bypass of a lone long-latency result
    applyStimulus(0, 0, 0, 0, 1, 5'd5, 32'hDEAD, 0, 0, 0, 0);
    checkOutput("tp1_wen", rf_wen, 1);
    checkOutput("tp1_addr", rf_rd_addr, 5);
    checkOutput("tp1_data", rf_rd_data, 32'hDEAD);
    idle(0, 0);

    // Fill the FIFO behind a busy pipeline, then drain in order
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      acc = (idx < 5) && (m_q.size() < DEPTH);
      applyStimulus(0, 1, 5'd12, 32'h100 + c, idx < 5, 5'd7 + 5'(idx), 32'hA0 + idx, 0, 0, 5'd7, 0);
      if (acc) idx++;
    end
    checkOutput("tp2_accepts", idx, 4);
    #1;
    checkOutput("tp2_full", lat_ready, 0);
    for (int c = 0; c < 8; c++) begin
      acc = (idx < 5) && (m_q.size() < DEPTH);
      applyStimulus(0, 0, 0, 0, idx < 5, 5'd7 + 5'(idx), 32'hA0 + idx, 0, 0, 5'd7, 0);
      if (acc) idx++;
      if (rf_wen) got.push_back(rf_rd_addr);
    end
    checkOutput("tp2_nwrites", got.size(), 5);
    for (int k = 0; k < 5; k++)
      checkOutput("tp2_order", (k < got.size()) ? got[k] : 5'd31, 5'd7 + 5'(k));

    // Set and clear of the same register in one cycle: set wins
    applyStimulus(0, 0, 0, 0, 1, 5'd3, 32'h33, 1, 5'd3, 5'd3, 0);
    checkOutput("tp3_busy", rs1_busy, 1);

    // x0 never goes busy but its writes still pass through
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 0);
    checkOutput("tp4_busy", rs1_busy, 0);
    applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'h55, 0, 0, 5'd0, 5'd3);
    checkOutput("tp4_wen", rf_wen, 1);
    checkOutput("tp4_addr", rf_rd_addr, 0);

    // Sticky WAW error
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 0, 0);
    applyStimulus(0, 1, 5'd4, 32'h44, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("tp5_err", err_waw, 1);
    for (int c = 0; c < 3; c++) idle(0, 0);
    checkOutput("tp5_sticky", err_waw, 1);
    doReset();
    checkOutput("tp5_cleared", err_waw, 0);

    // Reset with queued results discards everything
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0);
    for (int c = 0; c < 3; c++)
      applyStimulus(0, 1, 5'd20, 32'h200, 1, 5'd9 + 5'(c), 32'hB0 + c, 1, 5'd10 + 5'(c), 5'd9, 5'd10);
    doReset();
    checkOutput("tp6_wen", rf_wen, 0);
    checkOutput("tp6_ready", lat_ready, 1);
    for (int c = 0; c < 4; c++) begin
      idle(5'd9 + 5'(c), 5'd10 + 5'(c));
      checkOutput("tp6_nostale", rf_wen, 0);
    end

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 99) < 45, 5'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 99) < 60, 5'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 99) < 30, 5'($urandom_range(0, 15)),
                    5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
